// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter.
//   arb_state_t     : arbiter FSM states
//   PORT_FETCH/DATA : owner encoding (fetch = port 0, load/store = port 1)
//   ROM_SEL_BIT     : address bit that separates ROM (0) from RAM (1)
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;

  localparam logic PORT_FETCH  = 1'b0;
  localparam logic PORT_DATA   = 1'b1;
  localparam int   ROM_SEL_BIT = 10;

  // A store aimed below the RAM window is refused without touching Memory.
  function automatic logic is_rom_write(logic port, logic wr, logic rom_sel);
    return (port == PORT_DATA) && wr && !rom_sel;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select between the fetch and data ports.
// Build option: ARB_ROUND_ROBIN_EN
//   undefined : fixed priority, data port wins on contention
//   defined   : on contention the port not granted last wins (uses last_grant)
// Ports:
//   fetch_req, data_req : requests from port 0 / port 1
//   last_grant          : owner of the previous grant (round-robin build only)
//   grant_vld           : some request is pending
//   grant_port          : winning port (PORT_FETCH / PORT_DATA)
module arb_pick import mem_arb_pkg::*; (
  input  logic fetch_req,
  input  logic data_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic last_grant,
`endif
  output logic grant_vld,
  output logic grant_port
);

  always_comb begin
    grant_vld  = fetch_req | data_req;
    grant_port = data_req ? PORT_DATA : PORT_FETCH;
`ifdef ARB_ROUND_ROBIN_EN
    if (fetch_req && data_req) grant_port = ~last_grant;
`endif
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares the unified Memory between instruction fetch (port 0) and
// load/store (port 1). One access at a time: IDLE -> BUSY -> RESP -> IDLE.
// Build option: ARB_ROUND_ROBIN_EN (round-robin instead of data-first priority).
// Ports:
//   clk, resetN                  : clock, synchronous active-low reset
//   fetchReq/Address/Ack/Data    : port 0, read only
//   dataReq/Write/Address/Wdata  : port 1 request
//   dataAck/Rdata/Fault          : port 1 response; Fault flags a ROM write
//   memEnable/Address/ReadWrite/Wdata : command to Memory (held through BUSY)
//   memRdata                     : Memory read data, captured at end of BUSY
module memory_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              fetchReq,
  input  logic [ADDR_W-1:0] fetchAddress,
  output logic              fetchAck,
  output logic [DATA_W-1:0] fetchData,
  input  logic              dataReq,
  input  logic              dataWrite,
  input  logic [ADDR_W-1:0] dataAddress,
  input  logic [DATA_W-1:0] dataWdata,
  output logic              dataAck,
  output logic [DATA_W-1:0] dataRdata,
  output logic              dataFault,
  output logic              memEnable,
  output logic [ADDR_W-1:0] memAddress,
  output logic              memReadWrite,
  output logic [DATA_W-1:0] memWdata,
  input  logic [DATA_W-1:0] memRdata
);

  localparam int CNT_W = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              owner_q;
  logic              fault_q;
  logic [DATA_W-1:0] fetch_data_q;
  logic [DATA_W-1:0] data_rdata_q;

  logic              gnt_vld;
  logic              gnt_port;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_wr;
  logic              rom_wr;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_q;
`endif

  arb_pick u_pick (
    .fetch_req  (fetchReq),
    .data_req   (dataReq),
`ifdef ARB_ROUND_ROBIN_EN
    .last_grant (last_grant_q),
`endif
    .grant_vld  (gnt_vld),
    .grant_port (gnt_port)
  );

  assign sel_addr = (gnt_port == PORT_DATA) ? dataAddress : fetchAddress;
  assign sel_wr   = (gnt_port == PORT_DATA) & dataWrite;
  assign rom_wr   = is_rom_write(gnt_port, sel_wr, sel_addr[ROM_SEL_BIT]);

  // Next-state logic; requests are only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_vld) state_d = rom_wr ? RESP : BUSY;
      BUSY:    if (cnt_q == CNT_W'(1)) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wr_q         <= 1'b0;
      wdata_q      <= '0;
      owner_q      <= PORT_FETCH;
      fault_q      <= 1'b0;
      fetch_data_q <= '0;
      data_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= PORT_FETCH;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (gnt_vld) begin
          addr_q  <= sel_addr;
          wr_q    <= sel_wr;
          wdata_q <= dataWdata;
          owner_q <= gnt_port;
          fault_q <= rom_wr;
          cnt_q   <= CNT_W'(MEM_LATENCY);
`ifdef ARB_ROUND_ROBIN_EN
          // Tracks the actual winner; alternates whenever both keep requesting.
          last_grant_q <= gnt_port;
`endif
        end
        BUSY: begin
          cnt_q <= cnt_q - 1'b1;
          // Last BUSY cycle: read data is valid now. Writes leave read regs alone.
          if (cnt_q == CNT_W'(1) && !wr_q) begin
            if (owner_q == PORT_DATA) data_rdata_q <= memRdata;
            else                      fetch_data_q <= memRdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign memEnable    = (state_q == BUSY);
  assign memAddress   = addr_q;
  assign memReadWrite = wr_q;
  assign memWdata     = wdata_q;

  assign fetchAck  = (state_q == RESP) && (owner_q == PORT_FETCH);
  assign dataAck   = (state_q == RESP) && (owner_q == PORT_DATA);
  assign dataFault = dataAck && fault_q;
  assign fetchData = fetch_data_q;
  assign dataRdata = data_rdata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: one instance at MEM_LATENCY=1 for
// the functional scenarios and one at MEM_LATENCY=3 for the mid-BUSY reset.
module tb_memory_arbiter;

  logic        clk = 1'b0;
  logic        resetN;
  logic        fetchReq, dataReq, dataWrite;
  logic [31:0] fetchAddress, dataAddress, dataWdata, memRdata;

  logic        f_ack, d_ack, d_fault, m_en, m_rw;
  logic [31:0] f_data, d_rdata, m_addr, m_wdata;
  logic        f_ack3, d_ack3, d_fault3, m_en3, m_rw3;
  logic [31:0] f_data3, d_rdata3, m_addr3, m_wdata3;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference state: who was granted last, and the last data seen per port.
  logic        m_last  = 1'b0;
  logic [31:0] m_fdata = '0;
  logic [31:0] m_ddata = '0;

  always #5 clk = ~clk;

  memory_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut (
    .clk(clk), .resetN(resetN),
    .fetchReq(fetchReq), .fetchAddress(fetchAddress), .fetchAck(f_ack), .fetchData(f_data),
    .dataReq(dataReq), .dataWrite(dataWrite), .dataAddress(dataAddress), .dataWdata(dataWdata),
    .dataAck(d_ack), .dataRdata(d_rdata), .dataFault(d_fault),
    .memEnable(m_en), .memAddress(m_addr), .memReadWrite(m_rw), .memWdata(m_wdata),
    .memRdata(memRdata)
  );

  memory_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .resetN(resetN),
    .fetchReq(fetchReq), .fetchAddress(fetchAddress), .fetchAck(f_ack3), .fetchData(f_data3),
    .dataReq(dataReq), .dataWrite(dataWrite), .dataAddress(dataAddress), .dataWdata(dataWdata),
    .dataAck(d_ack3), .dataRdata(d_rdata3), .dataFault(d_fault3),
    .memEnable(m_en3), .memAddress(m_addr3), .memReadWrite(m_rw3), .memWdata(m_wdata3),
    .memRdata(memRdata)
  );

  // Winner rule from the arbitration policy (1 = data port).
  function automatic logic model_win(logic f, logic d);
`ifdef ARB_ROUND_ROBIN_EN
    if (f && d) return ~m_last;
`endif
    return d;
  endfunction

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    resetN = 1'b0; fetchReq = 1'b1; dataReq = 1'b1; dataWrite = 1'b0;
    fetchAddress = 32'h10; dataAddress = 32'h404; dataWdata = 32'h0; memRdata = 32'h0;
    repeat (3) step();
    checks++;
    if ({f_ack, f_data, d_ack, d_rdata, d_fault, m_en, m_addr, m_rw, m_wdata} !== '0) begin
      errors++; $display("FAIL reset_outputs: got en=%b ack=%b/%b addr=%h", m_en, f_ack, d_ack, m_addr);
    end
    checks++;
    if ({f_ack3, f_data3, d_ack3, d_rdata3, d_fault3, m_en3, m_addr3, m_rw3, m_wdata3} !== '0) begin
      errors++; $display("FAIL reset_outputs_lat3: got en=%b ack=%b/%b addr=%h", m_en3, f_ack3, d_ack3, m_addr3);
    end
    resetN = 1'b1;
    memRdata = $urandom;
    m_last = model_win(1'b1, 1'b1);
    step();
    checks++;
    if ({m_en, m_addr} !== {1'b1, (m_last ? 32'h404 : 32'h10)}) begin
      errors++; $display("FAIL reset_release_grant: got en=%b addr=%h", m_en, m_addr);
    end
    step();
    if (m_last) m_ddata = memRdata; else m_fdata = memRdata;
    checks++;
    if ({f_ack, d_ack, f_data, d_rdata} !== {~m_last, m_last, m_fdata, m_ddata}) begin
      errors++; $display("FAIL reset_release_ack: got ack=%b/%b data=%h/%h want data=%h/%h",
                         f_ack, d_ack, f_data, d_rdata, m_fdata, m_ddata);
    end
    fetchReq = 1'b0; dataReq = 1'b0;
    step();
  endtask

  task automatic test_fetch_read();
    fetchAddress = 32'h10; memRdata = 32'hDEADBEEF; fetchReq = 1'b1;
    m_last = 1'b0;
    step();
    checks++;
    if ({m_en, m_addr, m_rw, f_ack, d_ack} !== {1'b1, 32'h10, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL fetch_cmd: got en=%b addr=%h rw=%b ack=%b", m_en, m_addr, m_rw, f_ack);
    end
    step();
    m_fdata = 32'hDEADBEEF;
    checks++;
    if ({f_ack, f_data, m_en, d_ack} !== {1'b1, 32'hDEADBEEF, 1'b0, 1'b0}) begin
      errors++; $display("FAIL fetch_ack: got ack=%b data=%h en=%b want data=deadbeef", f_ack, f_data, m_en);
    end
    fetchReq = 1'b0;
    step();
    checks++;
    if ({f_ack, m_en, f_data} !== {1'b0, 1'b0, 32'hDEADBEEF}) begin
      errors++; $display("FAIL fetch_hold: got ack=%b en=%b data=%h", f_ack, m_en, f_data);
    end
  endtask

  task automatic test_contention();
    logic        w;
    logic [31:0] fa;
    int          last_ack = 0;
    fa = {$urandom_range(0, 511), 2'b00};
    fetchAddress = fa; dataAddress = 32'h404; dataWrite = 1'b0;
    fetchReq = 1'b1; dataReq = 1'b1;
    for (int g = 0; g < 5; g++) begin
      if (g == 4) dataReq = 1'b0;           // data port backs off for the last grant
      w = model_win(fetchReq, dataReq);
      m_last = w;
      memRdata = $urandom;
      step();
      checks++;
      if ({m_en, m_addr} !== {1'b1, (w ? 32'h404 : fa)}) begin
        errors++; $display("FAIL contention_cmd%0d: got en=%b addr=%h", g, m_en, m_addr);
      end
      step();
      if (w) m_ddata = memRdata; else m_fdata = memRdata;
      checks++;
      if ({f_ack, d_ack, f_data, d_rdata} !== {~w, w, m_fdata, m_ddata}) begin
        errors++; $display("FAIL contention_ack%0d: got ack=%b/%b data=%h/%h want ack=%b/%b",
                           g, f_ack, d_ack, f_data, d_rdata, ~w, w);
      end
      if (g > 0) begin
        checks++;
        if (cyc - last_ack !== 3) begin
          errors++; $display("FAIL contention_spacing%0d: got %0d cycles want 3", g, cyc - last_ack);
        end
      end
      last_ack = cyc;
      if (g == 4) fetchReq = 1'b0;
      step();
    end
  endtask

  task automatic test_ram_write();
    dataWrite = 1'b1; dataAddress = 32'h408; dataWdata = 32'h12345678;
    memRdata = $urandom; dataReq = 1'b1; m_last = 1'b1;
    step();
    checks++;
    if ({m_en, m_addr, m_rw, m_wdata} !== {1'b1, 32'h408, 1'b1, 32'h12345678}) begin
      errors++; $display("FAIL ram_write_cmd: got en=%b addr=%h rw=%b wdata=%h", m_en, m_addr, m_rw, m_wdata);
    end
    step();
    checks++;
    if ({d_ack, d_fault, f_ack, d_rdata} !== {1'b1, 1'b0, 1'b0, m_ddata}) begin
      errors++; $display("FAIL ram_write_ack: got ack=%b fault=%b rdata=%h want rdata=%h", d_ack, d_fault, d_rdata, m_ddata);
    end
    dataReq = 1'b0; dataWrite = 1'b0;
    step();
  endtask

  task automatic test_rom_write();
    dataWrite = 1'b1; dataAddress = 32'h008; dataWdata = $urandom; dataReq = 1'b1; m_last = 1'b1;
    step();
    checks++;
    if ({d_ack, d_fault, m_en, f_ack} !== {1'b1, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL rom_write_ack: got ack=%b fault=%b en=%b", d_ack, d_fault, m_en);
    end
    dataReq = 1'b0; dataWrite = 1'b0;
    step();
    checks++;
    if ({d_ack, d_fault, m_en} !== 3'b000) begin
      errors++; $display("FAIL rom_write_after: got ack=%b fault=%b en=%b", d_ack, d_fault, m_en);
    end
  endtask

  task automatic test_random();
    logic        port, wr, early, fault;
    logic [31:0] addr, rd, wd;
    for (int i = 0; i < 24; i++) begin
      port  = 1'($urandom_range(0, 1));
      wr    = port & 1'($urandom_range(0, 1));
      addr  = {20'h0, $urandom_range(0, 511) > 255 ? 1'b1 : 1'b0, 9'($urandom_range(0, 511)), 2'b00};
      rd    = $urandom; wd = $urandom;
      early = ($urandom_range(0, 3) == 0);
      fault = wr && !addr[10];
      memRdata = rd;
      if (port) begin dataReq = 1'b1; dataWrite = wr; dataAddress = addr; dataWdata = wd; end
      else      begin fetchReq = 1'b1; fetchAddress = addr; end
      m_last = port;
      if (!fault) begin
        step();
        checks++;
        if ({m_en, m_addr, m_rw, f_ack, d_ack} !== {1'b1, addr, wr, 1'b0, 1'b0} || (wr && m_wdata !== wd)) begin
          errors++; $display("FAIL random_cmd%0d: got en=%b addr=%h rw=%b wdata=%h want addr=%h rw=%b wdata=%h",
                             i, m_en, m_addr, m_rw, m_wdata, addr, wr, wd);
        end
        if (early) begin fetchReq = 1'b0; dataReq = 1'b0; end
        if (!port) m_fdata = rd; else if (!wr) m_ddata = rd;
      end
      step();
      checks++;
      if ({f_ack, d_ack, d_fault, f_data, d_rdata} !== {~port, port, fault, m_fdata, m_ddata}
          || (fault && m_en !== 1'b0)) begin
        errors++; $display("FAIL random_ack%0d: got ack=%b/%b fault=%b en=%b data=%h/%h want data=%h/%h",
                           i, f_ack, d_ack, d_fault, m_en, f_data, d_rdata, m_fdata, m_ddata);
      end
      fetchReq = 1'b0; dataReq = 1'b0; dataWrite = 1'b0;
      step();
      checks++;
      if ({f_ack, d_ack, m_en} !== 3'b000) begin
        errors++; $display("FAIL random_idle%0d: got ack=%b/%b en=%b", i, f_ack, d_ack, m_en);
      end
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [31:0] rd;
    int          acks = 0;
    fetchReq = 1'b0; dataReq = 1'b0; dataWrite = 1'b0;
    resetN = 1'b0;
    step();
    resetN = 1'b1;
    step();
    dataAddress = 32'h500; memRdata = $urandom; dataReq = 1'b1;
    step();
    step();
    checks++;
    if (m_en3 !== 1'b1) begin
      errors++; $display("FAIL midbusy_busy: got en=%b want 1", m_en3);
    end
    resetN = 1'b0; dataReq = 1'b0;     // 2nd BUSY cycle
    step();
    checks++;
    if ({m_en3, d_ack3, f_ack3} !== 3'b000) begin
      errors++; $display("FAIL midbusy_abort: got en=%b ack=%b/%b", m_en3, d_ack3, f_ack3);
    end
    resetN = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      if (d_ack3 || f_ack3 || m_en3) acks++;
    end
    checks++;
    if (acks !== 0) begin
      errors++; $display("FAIL midbusy_quiet: got %0d active cycles want 0", acks);
    end
    rd = $urandom; memRdata = rd; dataAddress = 32'h504; dataReq = 1'b1;
    acks = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (m_en3 === 1'b1 && m_addr3 === 32'h504 && d_ack3 === 1'b0) acks++;
    end
    checks++;
    if (acks !== 3) begin
      errors++; $display("FAIL midbusy_fresh_cmd: got %0d busy cycles want 3", acks);
    end
    step();
    checks++;
    if ({d_ack3, d_rdata3, m_en3} !== {1'b1, rd, 1'b0}) begin
      errors++; $display("FAIL midbusy_fresh_ack: got ack=%b rdata=%h en=%b want rdata=%h", d_ack3, d_rdata3, m_en3, rd);
    end
    dataReq = 1'b0;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fetch_read();
    test_contention();
    test_ram_write();
    test_rom_write();
    test_random();
    test_reset_mid_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
